// File: rtl/ltc_cnv_sequencer.sv
// ---------------------------------------------------------------------------
// ltc_cnv_sequencer
//
// Generates the ADC conversion strobe (cnv_o) that the LTC timestamp block
// captures on each rising edge. Pulses repeat every p_eff cycles and stay high
// h_eff cycles. They run free while enabled (trig_mode_i=0) or as bursts
// started by a software or external trigger (trig_mode_i=1). A slot whose
// start finds the timestamp FIFO full is skipped and counted as an overrun.
//
// Ports:
//   clk_i            sequencer clock (timer write clock domain)
//   aresetn_i        asynchronous active-low reset
//   enable_i         run enable; low aborts any activity
//   trig_mode_i      0 = free-run on enable, 1 = each trigger starts one burst
//   sw_trig_i        single-cycle software trigger, synchronous to clk_i
//   ext_trig_i       asynchronous external trigger, rising edge active
//   period_i         cycles per conversion slot
//   high_time_i      cnv high cycles
//   burst_len_i      conversions per burst, 0 = continuous
//   fifo_full_i      timestamp FIFO full
//   cnv_o            conversion strobe, registered
//   busy_o           high while not idle
//   done_o           one-cycle pulse at burst completion
//   cnv_count_o      pulses issued this run (wraps)
//   overrun_count_o  skipped slots this run (saturates)
// ---------------------------------------------------------------------------
module ltc_cnv_sequencer #(
    parameter int CNT_W       = 32,
    parameter int BURST_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               aresetn_i,
    input  logic               enable_i,
    input  logic               trig_mode_i,
    input  logic               sw_trig_i,
    input  logic               ext_trig_i,
    input  logic [CNT_W-1:0]   period_i,
    input  logic [CNT_W-1:0]   high_time_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               fifo_full_i,
    output logic               cnv_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [BURST_W-1:0] cnv_count_o,
    output logic [BURST_W-1:0] overrun_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     ph_q, ph_d;
    logic [CNT_W-1:0]     p_eff_q, p_eff_d;
    logic [CNT_W-1:0]     h_eff_q, h_eff_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [BURST_W-1:0]   slot_q, slot_d;
    logic                 slot_ok_q, slot_ok_d;
    logic                 cnv_q, cnv_d;
    logic [BURST_W-1:0]   cnv_cnt_q, cnv_cnt_d;
    logic [BURST_W-1:0]   ovr_cnt_q, ovr_cnt_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ext_prev_q;
    logic                   ext_edge_q;

    logic [CNT_W-1:0] h_eff_in;
    logic [CNT_W-1:0] p_eff_in;
    logic [CNT_W-1:0] ph_next;
    logic             ph_last;
    logic             start;
    logic             burst_end;

    // External trigger: synchronizer, then a registered rising-edge pulse.
    // NOTE: all sequential state is updated with <= so every register samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            sync_q     <= '0;
            ext_prev_q <= 1'b0;
            ext_edge_q <= 1'b0;
        end else begin
            sync_q     <= (sync_q << 1) | SYNC_STAGES'(ext_trig_i);
            ext_prev_q <= sync_q[SYNC_STAGES-1];
            ext_edge_q <= sync_q[SYNC_STAGES-1] & ~ext_prev_q;
        end
    end

    // Effective timing from the live inputs, latched only when a run starts.
    // With high_time all-ones, h_eff+1 wraps to 0 and the phase counter then
    // spans the full 2^CNT_W range, which is still one cycle longer than h_eff.
    assign h_eff_in  = (high_time_i == '0) ? CNT_W'(1) : high_time_i;
    assign p_eff_in  = (period_i > h_eff_in) ? period_i : h_eff_in + CNT_W'(1);

    assign start     = enable_i & (~trig_mode_i | sw_trig_i | ext_edge_q);
    assign ph_last   = (ph_q == p_eff_q - CNT_W'(1));
    assign ph_next   = ph_last ? '0 : ph_q + CNT_W'(1);
    assign burst_end = (burst_q != '0) && (slot_q == burst_q) && ph_last;

    // NOTE: every variable gets its default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        p_eff_d   = p_eff_q;
        h_eff_d   = h_eff_q;
        burst_d   = burst_q;
        slot_d    = slot_q;
        slot_ok_d = slot_ok_q;
        cnv_cnt_d = cnv_cnt_q;
        ovr_cnt_d = ovr_cnt_q;
        cnv_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // The first slot begins on the entry cycle itself.
                    state_d   = RUN;
                    p_eff_d   = p_eff_in;
                    h_eff_d   = h_eff_in;
                    burst_d   = burst_len_i;
                    ph_d      = '0;
                    slot_d    = BURST_W'(1);
                    slot_ok_d = ~fifo_full_i;
                    cnv_d     = ~fifo_full_i;
                    cnv_cnt_d = fifo_full_i ? '0 : BURST_W'(1);
                    ovr_cnt_d = fifo_full_i ? BURST_W'(1) : '0;
                end
            end
            RUN: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (burst_end) begin
                    state_d = DONE;
                end else begin
                    ph_d = ph_next;
                    if (ph_last) begin
                        // FIFO state is sampled once, at the slot boundary.
                        slot_d    = slot_q + BURST_W'(1);
                        slot_ok_d = ~fifo_full_i;
                        if (!fifo_full_i) begin
                            cnv_cnt_d = cnv_cnt_q + BURST_W'(1);
                        end else if (ovr_cnt_q != '1) begin
                            ovr_cnt_d = ovr_cnt_q + BURST_W'(1);
                        end
                    end
                    cnv_d = slot_ok_d && (ph_next < h_eff_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: asynchronous active-low reset clears every register, so cnv_o
    // drops the instant aresetn_i falls, without waiting for a clock.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q   <= IDLE;
            ph_q      <= '0;
            p_eff_q   <= '0;
            h_eff_q   <= '0;
            burst_q   <= '0;
            slot_q    <= '0;
            slot_ok_q <= 1'b0;
            cnv_q     <= 1'b0;
            cnv_cnt_q <= '0;
            ovr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            p_eff_q   <= p_eff_d;
            h_eff_q   <= h_eff_d;
            burst_q   <= burst_d;
            slot_q    <= slot_d;
            slot_ok_q <= slot_ok_d;
            cnv_q     <= cnv_d;
            cnv_cnt_q <= cnv_cnt_d;
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign cnv_o           = cnv_q;
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign cnv_count_o     = cnv_cnt_q;
    assign overrun_count_o = ovr_cnt_q;

endmodule

// File: doc/ltc_cnv_sequencer.md
Name: ltc_cnv_sequencer

Overview:
Generates the ADC conversion strobe `cnv` that the LTC timestamp block captures on each rising edge.
- Produces programmable-rate, programmable-width pulses as free-running streams or trigger-initiated bursts.
- Skips conversions while the downstream timestamp FIFO reports full, and counts the skips.
- Sits between the AXI parameter registers and the ADC/timer `cnv` net, in the `clk` domain.

Parameters:
- CNT_W, 32, width of the period and high-time counters.
- BURST_W, 16, width of the burst length, conversion count and overrun count.
- SYNC_STAGES, 2, synchronizer depth on `ext_trig`.

Ports:
- clk  in  1  sequencer clock, same as the timer write clock.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  run enable; low aborts any activity.
- trig_mode  in  1  0 = free-run on enable; 1 = each trigger starts one burst.
- sw_trig  in  1  single-cycle software trigger, synchronous to clk.
- ext_trig  in  1  asynchronous external trigger; rising edge is active.
- period  in  CNT_W  cycles per conversion slot.
- high_time  in  CNT_W  cnv high cycles.
- burst_len  in  BURST_W  conversions per burst; 0 = continuous.
- fifo_full  in  1  timestamp FIFO full.
- cnv  out  1  conversion strobe, registered.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse at burst completion.
- cnv_count  out  BURST_W  pulses issued this run.
- overrun_count  out  BURST_W  skipped slots, saturating.

Behaviour:
Reset (aresetn low, asynchronous):
- State IDLE; all counters 0; synchronizer and edge registers 0.
- cnv=0, busy=0, done=0, cnv_count=0, overrun_count=0.

Configuration latching:
- period, high_time and burst_len are latched on the IDLE->RUN transition and ignored afterwards.
- Effective values: h_eff = max(high_time, 1); p_eff = max(period, h_eff+1).

States:
- IDLE
  - trig_mode=0 and enable=1 -> RUN.
  - trig_mode=1 and enable=1 and a trigger event -> RUN.
  - A trigger event is sw_trig=1, or a rising edge on the synchronized ext_trig (one edge register after the synchronizer).
  - On entry to RUN: cnv_count and overrun_count clear to 0.
- RUN
  - Phase counter ph runs 0..p_eff-1 and wraps to 0.
  - At ph=0, slot_ok = !fifo_full, sampled once per slot.
  - cnv = slot_ok && (ph < h_eff), registered.
  - At ph=0 with slot_ok: cnv_count increments.
  - At ph=0 with !slot_ok: overrun_count increments, saturating at all-ones. Slot timing is unchanged (skip, not stall).
  - When burst_len!=0, the slot count reaches burst_len and ph=p_eff-1 -> DONE. Skipped slots count toward the burst.
- DONE
  - done=1 for this single cycle, then -> IDLE.
  - In trig_mode=0 with enable still high, the block re-enters RUN from IDLE on the next cycle, giving repeated bursts.

Timing:
- Start condition sampled at cycle N -> cnv=1 at cycle N+1 (first slot, fifo not full).
- ext_trig rising at cycle N -> cnv=1 at cycle N+SYNC_STAGES+2.
- Pulse stays high exactly h_eff cycles; rising-edge spacing is exactly p_eff cycles.

Boundary conditions:
- Triggers during RUN or DONE are ignored (no queuing).
- enable low in any state -> IDLE next cycle with cnv=0. This may truncate a pulse. No done pulse. Counters hold their values.
- sw_trig and an ext_trig edge in the same cycle count as one trigger.
- fifo_full changing mid-slot has no effect on the current slot.
- cnv_count wraps modulo 2^BURST_W in continuous mode.
- Reset mid-pulse forces cnv low immediately (asynchronous).

Test Plan:
1. trig_mode=0, period=10, high_time=3, burst_len=0, enable held high -> cnv rising edges every 10 cycles, each 3 cycles high; cnv_count reaches 5 after 50 cycles.
2. period=2, high_time=0 -> h_eff=1, p_eff=2; cnv toggles 1,0,1,0. period=3, high_time=5 -> p_eff=6, high 5 cycles.
3. trig_mode=1, burst_len=4, period=8, high_time=2, one sw_trig -> exactly 4 pulses, done pulse at cycle 32 after cnv first rises, busy falls the next cycle; a second sw_trig during the burst produces no extra pulses.
4. trig_mode=1, ext_trig async rising edge -> first cnv rise 4 cycles after the sampled edge (SYNC_STAGES=2); a 1-cycle glitch held under one clk is not required to trigger.
5. fifo_full asserted for slots 2 and 3 of a burst_len=5 burst -> 3 pulses, overrun_count=2, cnv_count=3, done at the same cycle as the unblocked case.
6. enable dropped on the second cycle of a high_time=4 pulse -> cnv=0 next cycle, state IDLE, no done; aresetn pulsed mid-run -> all outputs 0 asynchronously.
